// File: rtl/bank_mapped_burst_if.sv
// Command and data bundle between the bank-group decode (master) and one bank model (slave).
interface bank_mapped_burst_if #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int ROWWIDTH     = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd;
    logic [ROWWIDTH-1:0]     row;
    logic [COLWIDTH-1:0]     column;
    logic [DEVICE_WIDTH-1:0] dqin;
    logic [DEVICE_WIDTH-1:0] dqout;
    logic                    dq_valid;
    logic                    row_open;
    logic [CHWIDTH-1:0]      open_slot;
    logic                    alloc_err;
    logic                    cmd_err;

    modport master (
        output cmd_valid, cmd, row, column, dqin,
        input  cmd_ready, dqout, dq_valid, row_open, open_slot, alloc_err, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd, row, column, dqin,
        output cmd_ready, dqout, dq_valid, row_open, open_slot, alloc_err, cmd_err
    );
endinterface

// File: rtl/bank_mapped_burst.sv
// Bank model: small slot pool mapped onto the DRAM row space, ACT/RD/WR/PRE with BL-beat wrapped bursts.
// Latency: read data 1 cycle after each address beat; ACT/errors visible the cycle after acceptance.
// Backpressure: cmd_ready low for the BL cycles of a burst; BANK_EVICT_EN enables round-robin eviction.
module bank_mapped_burst #(
    parameter int DEVICE_WIDTH = 4,
    parameter int COLWIDTH     = 10,
    parameter int CHWIDTH      = 5,
    parameter int ROWWIDTH     = 16,
    parameter int BL           = 8
) (
    input  logic               clk,
    input  logic               rst,
    bank_mapped_burst_if.slave bus
);
    localparam int CHROWS = 2 ** CHWIDTH;
    localparam int COLS   = 2 ** COLWIDTH;
    localparam int LOG_BL = $clog2(BL);
    localparam logic [COLWIDTH-1:0] BL_MASK   = COLWIDTH'(BL - 1);
    localparam logic [LOG_BL-1:0]   LAST_BEAT = LOG_BL'(BL - 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {IDLE, ACTIVE, RBURST, WBURST} state_t;

    state_t                  state_q, state_d;
    logic [CHROWS-1:0]       map_vld;
    logic [ROWWIDTH-1:0]     map_tag [CHROWS];
    logic [DEVICE_WIDTH-1:0] mem [CHROWS*COLS];
    logic [CHWIDTH-1:0]      slot_q;
    logic [COLWIDTH-1:0]     col_q;
    logic [LOG_BL-1:0]       beat_q;
    logic [DEVICE_WIDTH-1:0] rd_dat;
    logic                    dq_vld_q, alloc_err_q, cmd_err_q;

    logic                    ready, accept;
    logic                    hit, free_found;
    logic [CHWIDTH-1:0]      hit_idx, free_idx, act_slot;
    logic                    act_take, retag, alloc_fail, illegal, burst_start;
    logic [COLWIDTH-1:0]     beat_col;
    logic [CHWIDTH+COLWIDTH-1:0] mem_addr;

    assign ready  = (state_q == IDLE) || (state_q == ACTIVE);
    assign accept = bus.cmd_valid & ready;

    // First matching tag and lowest free entry, both searched in one pass.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < CHROWS; i++) begin
            if (map_vld[i] && (map_tag[i] == bus.row) && !hit) begin
                hit     = 1'b1;
                hit_idx = CHWIDTH'(i);
            end
            if (!map_vld[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = CHWIDTH'(i);
            end
        end
    end

`ifdef BANK_EVICT_EN
    logic               evict;
    logic [CHWIDTH-1:0] evict_ptr;

    always_ff @(posedge clk) begin
        if (rst)        evict_ptr <= '0;
        else if (evict) evict_ptr <= evict_ptr + CHWIDTH'(1);
    end
`endif

    always_comb begin
        state_d     = state_q;
        act_take    = 1'b0;
        act_slot    = hit_idx;
        retag       = 1'b0;
        alloc_fail  = 1'b0;
        illegal     = 1'b0;
        burst_start = 1'b0;
`ifdef BANK_EVICT_EN
        evict       = 1'b0;
`endif
        case (state_q)
            IDLE: if (accept) begin
                if (bus.cmd != CMD_ACT) begin
                    illegal = 1'b1;
                end else if (hit) begin
                    act_take = 1'b1;
                    state_d  = ACTIVE;
                end else if (free_found) begin
                    act_take = 1'b1;
                    retag    = 1'b1;
                    act_slot = free_idx;
                    state_d  = ACTIVE;
                end else begin
`ifdef BANK_EVICT_EN
                    act_take = 1'b1;
                    retag    = 1'b1;
                    evict    = 1'b1;
                    act_slot = evict_ptr;
                    state_d  = ACTIVE;
`else
                    alloc_fail = 1'b1;
`endif
                end
            end
            ACTIVE: if (accept) begin
                case (bus.cmd)
                    CMD_RD:  begin state_d = RBURST; burst_start = 1'b1; end
                    CMD_WR:  begin state_d = WBURST; burst_start = 1'b1; end
                    CMD_PRE: state_d = IDLE;
                    default: illegal = 1'b1;
                endcase
            end
            RBURST, WBURST: if (beat_q == LAST_BEAT) state_d = ACTIVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_vld     <= '0;
            slot_q      <= '0;
            col_q       <= '0;
            beat_q      <= '0;
            dq_vld_q    <= 1'b0;
            alloc_err_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            alloc_err_q <= alloc_fail;
            cmd_err_q   <= illegal;
            dq_vld_q    <= (state_q == RBURST);
            if (act_take) slot_q <= act_slot;
            if (retag)    map_vld[act_slot] <= 1'b1;
            if (burst_start) begin
                col_q  <= bus.column;
                beat_q <= '0;
            end else if ((state_q == RBURST) || (state_q == WBURST)) begin
                beat_q <= beat_q + LOG_BL'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && retag) map_tag[act_slot] <= bus.row;
    end

    // Low column bits wrap inside the BL-aligned block; upper bits stay fixed.
    assign beat_col = (col_q & ~BL_MASK) | ((col_q + COLWIDTH'(beat_q)) & BL_MASK);
    assign mem_addr = {slot_q, beat_col};

    always_ff @(posedge clk) begin
        if ((state_q == WBURST) && !rst) mem[mem_addr] <= bus.dqin;
        rd_dat <= mem[mem_addr];
    end

    assign bus.cmd_ready = ready;
    assign bus.dqout     = dq_vld_q ? rd_dat : '0;
    assign bus.dq_valid  = dq_vld_q;
    assign bus.row_open  = (state_q != IDLE);
    assign bus.open_slot = slot_q;
    assign bus.alloc_err = alloc_err_q;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_bank_mapped_burst.sv
// Scoreboard bench: a row-map/memory model predicts read beats and status; a negedge monitor checks read data.
module tb_bank_mapped_burst;
    localparam int BL    = 8;
    localparam int NSLOT = 32;
    localparam int COLS  = 1024;
    localparam logic [1:0] ACT = 2'b00, RD = 2'b01, WR = 2'b10, PRE = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bank_mapped_burst_if #(.DEVICE_WIDTH(4), .COLWIDTH(10), .CHWIDTH(5), .ROWWIDTH(16)) bus ();

    bank_mapped_burst #(.DEVICE_WIDTH(4), .COLWIDTH(10), .CHWIDTH(5), .ROWWIDTH(16), .BL(BL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests  = 0;
    int failed = 0;

    typedef struct {logic [3:0] d; bit care;} beat_t;
    beat_t exp_q[$];

    bit          m_vld [NSLOT];
    logic [15:0] m_tag [NSLOT];
    bit          m_open;
    int          m_slot;
    int          m_ptr;
    logic [3:0]  m_mem [int];
    logic [3:0]  wbuf  [BL];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    function automatic int col_of(input int col, input int i);
        return (col & ~(BL - 1)) | ((col + i) & (BL - 1));
    endfunction

    task automatic model_reset();
        foreach (m_vld[i]) m_vld[i] = 1'b0;
        m_open = 1'b0;
        m_slot = 0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    // Read-data monitor: every valid beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        beat_t b;
        if (bus.dq_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL rd_unexpected: got dq_valid=1 dqout=0x%0h, expected no read beat", bus.dqout);
            end else begin
                b = exp_q.pop_front();
                if (b.care) chk("rd_data", 32'(bus.dqout), 32'(b.d));
            end
        end
    end

    // Present a command and hold it until accepted; waits = cycles spent with cmd_ready low.
    task automatic send(input logic [1:0] c, input logic [15:0] r, input logic [9:0] col, output int waits);
        waits = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd    = c;
        bus.row    = r;
        bus.column = col;
        @(negedge clk);
        while (!bus.cmd_ready && waits < 64) begin
            waits++;
            @(negedge clk);
        end
        chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] c, input logic [15:0] r, input logic [9:0] col, output int waits);
        int    slot;
        bit    e_err, e_alloc, burst;
        int    key;
        beat_t b;
        slot = -1; e_err = 0; e_alloc = 0; burst = 0;
        if (!m_open) begin
            if (c == ACT) begin
                for (int i = 0; i < NSLOT; i++)
                    if (slot < 0 && m_vld[i] && m_tag[i] == r) slot = i;
                for (int i = 0; i < NSLOT; i++)
                    if (slot < 0 && !m_vld[i]) slot = i;
                if (slot < 0) begin
`ifdef BANK_EVICT_EN
                    slot  = m_ptr;
                    m_ptr = (m_ptr + 1) % NSLOT;
`else
                    e_alloc = 1;
`endif
                end
                if (slot >= 0) begin
                    m_vld[slot] = 1'b1;
                    m_tag[slot] = r;
                    m_open = 1'b1;
                    m_slot = slot;
                end
            end else begin
                e_err = 1;
            end
        end else begin
            case (c)
                ACT:     e_err = 1;
                PRE:     m_open = 1'b0;
                default: burst = 1;
            endcase
        end
        send(c, r, col, waits);
        if (burst && c == RD) begin
            for (int i = 0; i < BL; i++) begin
                key    = m_slot * COLS + col_of(col, i);
                b.care = m_mem.exists(key);
                b.d    = b.care ? m_mem[key] : 4'h0;
                exp_q.push_back(b);
            end
        end else if (burst) begin
            for (int i = 0; i < BL; i++) begin
                bus.dqin = wbuf[i];
                m_mem[m_slot * COLS + col_of(col, i)] = wbuf[i];
                @(negedge clk);
                chk("wr_busy_ready", 32'(bus.cmd_ready), 32'd0);
                @(posedge clk);
                #1;
            end
            bus.dqin = 4'h0;
            @(negedge clk);
            chk("wr_done_ready", 32'(bus.cmd_ready), 32'd1);
            chk("wr_done_open", 32'(bus.row_open), 32'd1);
            @(posedge clk);
            #1;
        end else begin
            @(negedge clk);
            chk("cmd_err", 32'(bus.cmd_err), 32'(e_err));
            chk("alloc_err", 32'(bus.alloc_err), 32'(e_alloc));
            chk("row_open", 32'(bus.row_open), 32'(m_open));
            if (m_open) chk("open_slot", 32'(bus.open_slot), 32'(m_slot));
            if (e_err || e_alloc) begin
                @(negedge clk);
                chk("cmd_err_pulse", 32'(bus.cmd_err), 32'd0);
                chk("alloc_err_pulse", 32'(bus.alloc_err), 32'd0);
                chk("err_state_kept", 32'(bus.row_open), 32'(m_open));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Write burst aborted by reset asserted on the edge that would store beat `abort_beat`.
    task automatic wr_abort(input logic [9:0] col, input int abort_beat);
        int w;
        send(WR, 16'h0, col, w);
        for (int i = 0; i < abort_beat; i++) begin
            bus.dqin = wbuf[i];
            m_mem[m_slot * COLS + col_of(col, i)] = wbuf[i];
            @(posedge clk);
            #1;
        end
        bus.dqin = wbuf[abort_beat];
        reset_dut();
        bus.dqin = 4'h0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, pick;
        logic [1:0] c;
        bus.cmd_valid = 1'b0;
        bus.cmd    = 2'b00;
        bus.row    = 16'h0;
        bus.column = 10'h0;
        bus.dqin   = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_dq_valid", 32'(bus.dq_valid), 32'd0);
        chk("rst_dqout", 32'(bus.dqout), 32'd0);
        chk("rst_row_open", 32'(bus.row_open), 32'd0);
        chk("rst_open_slot", 32'(bus.open_slot), 32'd0);
        chk("rst_alloc_err", 32'(bus.alloc_err), 32'd0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        @(posedge clk);
        #1;

        // Wrapped write then wrapped read in the same block.
        do_cmd(ACT, 16'h1234, 10'd0, w);
        for (int i = 0; i < BL; i++) wbuf[i] = 4'(i + 1);
        do_cmd(WR, 16'h0, 10'd5, w);
        do_cmd(RD, 16'h0, 10'd0, w);

        // Mapping persists across PRE/ACT.
        do_cmd(PRE, 16'h0, 10'd0, w);
        do_cmd(ACT, 16'h0042, 10'd0, w);
        do_cmd(PRE, 16'h0, 10'd0, w);
        do_cmd(ACT, 16'h1234, 10'd0, w);
        do_cmd(RD, 16'h0, 10'd3, w);

        // Illegal commands.
        do_cmd(ACT, 16'h0042, 10'd0, w);
        do_cmd(PRE, 16'h0, 10'd0, w);
        do_cmd(RD, 16'h0, 10'd0, w);
        do_cmd(PRE, 16'h0, 10'd0, w);

        // Held command during a read burst; back-to-back reads.
        do_cmd(ACT, 16'h1234, 10'd0, w);
        do_cmd(RD, 16'h0, 10'd0, w);
        do_cmd(RD, 16'h0, 10'd6, w2);
        chk("rd_hold_waits", 32'(w2), 32'(BL));
        do_cmd(PRE, 16'h0, 10'd0, w);

        // Fill every slot, then miss.
        reset_dut();
        for (int i = 0; i < NSLOT; i++) begin
            do_cmd(ACT, 16'h2000 + 16'(i), 10'd0, w);
            do_cmd(PRE, 16'h0, 10'd0, w);
        end
        do_cmd(ACT, 16'h3000, 10'd0, w);
`ifdef BANK_EVICT_EN
        do_cmd(PRE, 16'h0, 10'd0, w);
        do_cmd(ACT, 16'h3001, 10'd0, w);
        do_cmd(PRE, 16'h0, 10'd0, w);
`endif

        // Reset in the middle of a write burst.
        reset_dut();
        do_cmd(ACT, 16'h1234, 10'd0, w);
        for (int i = 0; i < BL; i++) wbuf[i] = 4'(i + 9);
        do_cmd(WR, 16'h0, 10'd16, w);
        for (int i = 0; i < BL; i++) wbuf[i] = 4'(2 * i + 2);
        wr_abort(10'd16, 3);
        @(negedge clk);
        chk("abort_dq_valid", 32'(bus.dq_valid), 32'd0);
        chk("abort_row_open", 32'(bus.row_open), 32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        do_cmd(ACT, 16'h0777, 10'd0, w);
        chk("abort_table_cleared", 32'(m_slot), 32'(bus.open_slot));
        do_cmd(RD, 16'h0, 10'd16, w);
        do_cmd(PRE, 16'h0, 10'd0, w);

        // Randomized traffic against the model.
        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 99);
            if (!m_open) c = (pick < 80) ? ACT : ((pick < 90) ? RD : PRE);
            else c = (pick < 35) ? RD : ((pick < 70) ? WR : ((pick < 90) ? PRE : ACT));
            for (int i = 0; i < BL; i++) wbuf[i] = 4'($urandom_range(0, 15));
            do_cmd(c, 16'h0100 + 16'($urandom_range(0, 39)), 10'($urandom_range(0, COLS - 1)), w);
        end

        repeat (BL + 4) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
